mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TMO_CYC, 16, cycles in WAIT without mc_ready before timeout
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1 clock
- reset input 1 synchronous active-high reset
- a_req_valid input 1 port A request present
- a_req_we input 1 port A: 1=write, 0=read
- a_req_addr input ADDR_W port A address
- a_req_wdata input DATA_W port A write data
- a_req_ready output 1 port A request accepted this cycle
- a_rsp_valid output 1 port A response pulse
- b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_ready, b_rsp_valid: as port A, for port B
- rsp_data output DATA_W read data, shared, valid with either rsp_valid
- timeout_err output 1 timeout pulse, coincident with rsp_valid
- mc_write_en output 1 write command to memory controller
- mc_read_en output 1 read command to memory controller
- mc_addr output ADDR_W command address
- mc_data_in output DATA_W command write data
- mc_data_out input DATA_W controller read data
- mc_ready input 1 controller completion
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high on port reset.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 In IDLE, x_req_ready SHALL be high combinationally for exactly the granted port when its x_req_valid is high, else low; all other states drive both req_ready low.
REQ-006 Accept (valid&ready at cycle T) SHALL latch we/addr/wdata and the granted port, then go to ISSUE.
REQ-007 ISSUE (T+1) SHALL assert exactly one of mc_write_en/mc_read_en for one cycle with mc_addr/mc_data_in from the latched request, then go to WAIT.
REQ-008 WAIT SHALL sample mc_ready; on mc_ready=1, capture mc_data_out into rsp_data for reads, leave rsp_data at 0 for writes, and go to RESP.
REQ-009 RESP SHALL pulse the granted port's rsp_valid for one cycle and return to IDLE; a write with mc_ready at T+2 yields rsp_valid at T+3.
REQ-010 mc_ready seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-011 A WAIT counter SHALL count cycles; if TMO_CYC cycles pass without mc_ready, go to RESP with rsp_data=0 and timeout_err high with rsp_valid.
REQ-012 mc_write_en, mc_read_en and a/b_rsp_valid SHALL never be high outside ISSUE/RESP respectively; at most one request is outstanding.
REQ-013 Requesters SHALL hold request fields stable while valid and not ready; the block SHALL not accept a new request until RESP completes.
REQ-014 With only one valid port in IDLE, that port SHALL be granted regardless of arbitration history.

Reset
REQ-015 Reset SHALL force IDLE and clear the WAIT counter and latched request; all outputs SHALL be 0.
REQ-016 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abort with no rsp_valid and no timeout_err; last-grant SHALL reset to B, so A wins first.

Configuration
REQ-017 Macro MEM_ARB_ROUND_ROBIN_EN defined: with both ports valid in IDLE, grant the port not granted last; last-grant updates on each accept.
REQ-018 Macro undefined: with both ports valid, port A SHALL always win; the last-grant register SHALL be absent.

Verification
REQ-019 A write addr=0x10 data=0x5A, mc_ready at T+2 -> mc_write_en only at T+1, a_rsp_valid at T+3, rsp_data=0x00.
REQ-020 B read addr=0x10, mc_data_out=0x5A with mc_ready -> b_rsp_valid one cycle, rsp_data=0x5A.
REQ-021 A and B valid together for 3 transactions -> with macro grants A,B,A; without macro A,A,A.
REQ-022 A read, mc_ready never asserted -> after 16 WAIT cycles, a_rsp_valid=1, timeout_err=1, rsp_data=0x00, then IDLE.
REQ-023 reset in WAIT, mc_ready next cycle -> no rsp_valid, all outputs 0, next request served normally.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-port memory request arbiter: one outstanding request, IDLE/ISSUE/WAIT/RESP sequencing, WAIT timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; default build gives port A fixed priority.
module mem_req_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req_valid,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_req_ready,
    output logic              a_rsp_valid,
    input  logic              b_req_valid,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_req_ready,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              timeout_err,
    output logic              mc_write_en,
    output logic              mc_read_en,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_data_in,
    input  logic [DATA_W-1:0] mc_data_out,
    input  logic              mc_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_we;
    logic              lat_port_b;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rsp_data_q;
    logic              tmo_flag;

    logic in_idle;
    logic in_issue;
    logic in_resp;
    logic grant_b;
    logic accept;

    assign in_idle  = (state == S_IDLE);
    assign in_issue = (state == S_ISSUE);
    assign in_resp  = (state == S_RESP);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_b remembers which port won the previous accept; B after reset so A wins first.
    logic last_b;

    always_comb begin
        grant_b = b_req_valid && (!a_req_valid || !last_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (accept) begin
            last_b <= grant_b;
        end
    end
`else
    always_comb begin
        grant_b = b_req_valid && !a_req_valid;
    end
`endif

    assign a_req_ready = in_idle && a_req_valid && !grant_b;
    assign b_req_ready = in_idle && grant_b;
    assign accept      = a_req_ready || b_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_port_b <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_data_q <= '0;
            tmo_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_port_b <= grant_b;
                        lat_we     <= grant_b ? b_req_we    : a_req_we;
                        lat_addr   <= grant_b ? b_req_addr  : a_req_addr;
                        lat_wdata  <= grant_b ? b_req_wdata : a_req_wdata;
                        rsp_data_q <= '0;
                        tmo_flag   <= 1'b0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over the timeout on the last counted cycle.
                    if (mc_ready) begin
                        if (!lat_we) begin
                            rsp_data_q <= mc_data_out;
                        end
                        state <= S_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        tmo_flag <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mc_write_en = in_issue && lat_we;
    assign mc_read_en  = in_issue && !lat_we;
    assign mc_addr     = in_issue ? lat_addr  : '0;
    assign mc_data_in  = in_issue ? lat_wdata : '0;

    assign a_rsp_valid = in_resp && !lat_port_b;
    assign b_rsp_valid = in_resp && lat_port_b;
    assign timeout_err = in_resp && tmo_flag;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant, command, latency and response.
module tb_mem_req_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req_valid, a_req_we, b_req_valid, b_req_we;
    logic [ADDR_W-1:0] a_req_addr, b_req_addr;
    logic [DATA_W-1:0] a_req_wdata, b_req_wdata;
    logic              a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              timeout_err, mc_write_en, mc_read_en;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data_in, mc_data_out;
    logic              mc_ready;

    int errors = 0;
    int checks = 0;

    mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
        .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
        .rsp_data(rsp_data), .timeout_err(timeout_err),
        .mc_write_en(mc_write_en), .mc_read_en(mc_read_en), .mc_addr(mc_addr),
        .mc_data_in(mc_data_in), .mc_data_out(mc_data_out), .mc_ready(mc_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [30:0] all_outs();
        return {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, rsp_data, timeout_err,
                mc_write_en, mc_read_en, mc_addr, mc_data_in};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        mc_data_out = '0; mc_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        #1;
        checks++;
        if (all_outs() !== 31'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_outs());
        end
    endtask

    task automatic test_write_a();
        cyc();
        a_req_valid = 1; a_req_we = 1; a_req_addr = 8'h10; a_req_wdata = 8'h5A;
        #1;
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b10) begin
            errors++; $display("FAIL wr_ready got %b want 10", {a_req_ready, b_req_ready});
        end
        cyc();
        a_req_valid = 0;
        #1;
        checks++;
        if ({mc_write_en, mc_read_en, mc_addr, mc_data_in, a_req_ready} !== {2'b10, 8'h10, 8'h5A, 1'b0}) begin
            errors++; $display("FAIL wr_issue got we=%b re=%b addr=%h din=%h want 1 0 10 5a",
                               mc_write_en, mc_read_en, mc_addr, mc_data_in);
        end
        cyc();
        mc_ready = 1;
        #1;
        checks++;
        if ({mc_write_en, a_rsp_valid, b_rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL wr_wait got we=%b rv=%b%b want 000", mc_write_en, a_rsp_valid, b_rsp_valid);
        end
        cyc();
        mc_ready = 0;
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid, rsp_data, timeout_err} !== {2'b10, 8'h00, 1'b0}) begin
            errors++; $display("FAIL wr_resp got a=%b b=%b data=%h tmo=%b want 1 0 00 0",
                               a_rsp_valid, b_rsp_valid, rsp_data, timeout_err);
        end
        cyc();
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rsp_pulse got %b want 0", a_rsp_valid);
        end
    endtask

    task automatic test_read_b();
        cyc();
        b_req_valid = 1; b_req_we = 0; b_req_addr = 8'h10; mc_ready = 1;
        #1;
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_ready got %b want 01", {a_req_ready, b_req_ready});
        end
        cyc();
        b_req_valid = 0;
        #1;
        checks++;
        if ({mc_write_en, mc_read_en, mc_addr} !== {2'b01, 8'h10}) begin
            errors++; $display("FAIL rd_issue got we=%b re=%b addr=%h want 0 1 10", mc_write_en, mc_read_en, mc_addr);
        end
        cyc();
        mc_ready = 0;
        #1;
        cyc();
        mc_ready = 1; mc_data_out = 8'h5A;
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL rd_early_rsp got %b want 00", {a_rsp_valid, b_rsp_valid});
        end
        cyc();
        mc_ready = 0; mc_data_out = 8'h00;
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid, rsp_data, timeout_err} !== {2'b01, 8'h5A, 1'b0}) begin
            errors++; $display("FAIL rd_resp got a=%b b=%b data=%h tmo=%b want 0 1 5a 0",
                               a_rsp_valid, b_rsp_valid, rsp_data, timeout_err);
        end
        cyc();
        #1;
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_rsp_pulse got %b want 0", b_rsp_valid);
        end
    endtask

    task automatic test_arbitration();
        bit last_b;
        bit exp_b;
        do_reset();
        last_b = 1'b1;
        for (int t = 0; t < 3; t++) begin
            exp_b = RR ? !last_b : 1'b0;
            cyc();
            a_req_valid = 1; a_req_we = 1; a_req_addr = 8'(8'h20 + t); a_req_wdata = 8'hA0;
            b_req_valid = 1; b_req_we = 1; b_req_addr = 8'(8'h40 + t); b_req_wdata = 8'hB0;
            #1;
            checks++;
            if ({a_req_ready, b_req_ready} !== {!exp_b, exp_b}) begin
                errors++; $display("FAIL arb_grant%0d got %b want %b", t, {a_req_ready, b_req_ready}, {!exp_b, exp_b});
            end
            cyc();
            a_req_valid = 0; b_req_valid = 0;
            #1;
            checks++;
            if (mc_addr !== (exp_b ? 8'(8'h40 + t) : 8'(8'h20 + t))) begin
                errors++; $display("FAIL arb_addr%0d got %h", t, mc_addr);
            end
            cyc();
            mc_ready = 1;
            cyc();
            mc_ready = 0;
            #1;
            checks++;
            if ({a_rsp_valid, b_rsp_valid} !== {!exp_b, exp_b}) begin
                errors++; $display("FAIL arb_rsp%0d got %b want %b", t, {a_rsp_valid, b_rsp_valid}, {!exp_b, exp_b});
            end
            last_b = exp_b;
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        cyc();
        a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h33;
        cyc();
        a_req_valid = 0;
        #1;
        checks++;
        if (mc_read_en !== 1'b1) begin
            errors++; $display("FAIL tmo_issue got %b want 1", mc_read_en);
        end
        for (int i = 0; i < TMO_CYC; i++) begin
            cyc();
            mc_data_out = 8'hEE;
            #1;
            if (a_rsp_valid || timeout_err) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL tmo_early got %0d early responses want 0", early);
        end
        cyc();
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid, timeout_err, rsp_data} !== {3'b101, 8'h00}) begin
            errors++; $display("FAIL tmo_resp got a=%b b=%b tmo=%b data=%h want 1 0 1 00",
                               a_rsp_valid, b_rsp_valid, timeout_err, rsp_data);
        end
        cyc();
        a_req_valid = 1;
        #1;
        checks++;
        if ({a_rsp_valid, timeout_err, a_req_ready} !== 3'b001) begin
            errors++; $display("FAIL tmo_idle got rsp=%b tmo=%b rdy=%b want 0 0 1", a_rsp_valid, timeout_err, a_req_ready);
        end
        a_req_valid = 0;
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        do_reset();
        cyc();
        a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h77;
        cyc();
        a_req_valid = 0;
        cyc();
        cyc();
        reset = 1;
        cyc();
        reset = 0; mc_ready = 1; mc_data_out = 8'h99;
        #1;
        checks++;
        if (all_outs() !== 31'd0) begin
            errors++; $display("FAIL rst_mid_outs got %h want 0", all_outs());
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            mc_ready = 0;
            #1;
            if (all_outs() !== 31'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_mid_quiet got %0d nonzero cycles want 0", bad);
        end
        cyc();
        a_req_valid = 1; a_req_we = 1; a_req_addr = 8'h12; a_req_wdata = 8'h34;
        b_req_valid = 1; b_req_we = 1; b_req_addr = 8'h56; b_req_wdata = 8'h78;
        #1;
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_grant got %b want 10", {a_req_ready, b_req_ready});
        end
        cyc();
        a_req_valid = 0; b_req_valid = 0;
        #1;
        checks++;
        if ({mc_write_en, mc_addr, mc_data_in} !== {1'b1, 8'h12, 8'h34}) begin
            errors++; $display("FAIL rst_mid_issue got we=%b addr=%h din=%h want 1 12 34", mc_write_en, mc_addr, mc_data_in);
        end
        cyc();
        mc_ready = 1;
        cyc();
        mc_ready = 0;
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid, timeout_err} !== 3'b100) begin
            errors++; $display("FAIL rst_mid_resp got %b want 100", {a_rsp_valid, b_rsp_valid, timeout_err});
        end
    endtask

    task automatic test_random();
        bit last_b, av, bv, gb, we, tmo;
        logic [ADDR_W-1:0] ad_a, ad_b, ad;
        logic [DATA_W-1:0] wd_a, wd_b, wd, rd, exp_data;
        int d, wcyc, bad;
        do_reset();
        last_b = 1'b1;
        for (int t = 0; t < 40; t++) begin
            do begin
                av = 1'($urandom_range(0, 1));
                bv = 1'($urandom_range(0, 1));
            end while (!av && !bv);
            gb = bv && (!av || (RR && !last_b));
            ad_a = 8'($urandom); ad_b = 8'($urandom); wd_a = 8'($urandom); wd_b = 8'($urandom);
            d = $urandom_range(0, TMO_CYC + 2);
            cyc();
            a_req_valid = av; a_req_we = 1'($urandom_range(0, 1)); a_req_addr = ad_a; a_req_wdata = wd_a;
            b_req_valid = bv; b_req_we = 1'($urandom_range(0, 1)); b_req_addr = ad_b; b_req_wdata = wd_b;
            mc_ready = 1'($urandom_range(0, 1));
            we = gb ? b_req_we : a_req_we;
            ad = gb ? ad_b : ad_a;
            wd = gb ? wd_b : wd_a;
            #1;
            checks++;
            if ({a_req_ready, b_req_ready} !== {av && !gb, gb}) begin
                errors++; $display("FAIL rnd_grant%0d got %b want %b", t, {a_req_ready, b_req_ready}, {av && !gb, gb});
            end
            cyc();
            a_req_valid = 0; b_req_valid = 0;
            mc_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({mc_write_en, mc_read_en, mc_addr, mc_data_in} !== {we, !we, ad, wd}) begin
                errors++; $display("FAIL rnd_issue%0d got we=%b re=%b addr=%h din=%h want %b %b %h %h",
                                   t, mc_write_en, mc_read_en, mc_addr, mc_data_in, we, !we, ad, wd);
            end
            tmo = (d >= TMO_CYC);
            wcyc = tmo ? TMO_CYC : d + 1;
            bad = 0;
            rd = '0;
            for (int i = 0; i < wcyc; i++) begin
                cyc();
                mc_ready = (i == d);
                mc_data_out = 8'($urandom);
                if (i == d) rd = mc_data_out;
                #1;
                if (a_rsp_valid || b_rsp_valid || mc_write_en || mc_read_en || a_req_ready || b_req_ready) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rnd_wait%0d got %0d bad cycles want 0", t, bad);
            end
            exp_data = (!we && !tmo) ? rd : 8'h00;
            cyc();
            mc_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({a_rsp_valid, b_rsp_valid, timeout_err, rsp_data} !== {!gb, gb, tmo, exp_data}) begin
                errors++; $display("FAIL rnd_resp%0d got a=%b b=%b tmo=%b data=%h want %b %b %b %h",
                                   t, a_rsp_valid, b_rsp_valid, timeout_err, rsp_data, !gb, gb, tmo, exp_data);
            end
            last_b = gb;
        end
        cyc();
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write_a();
        test_read_b();
        test_arbitration();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
